// File: rtl/glyph_fetch_sched_if.sv
// Host read port of the glyph ROM scheduler.
// Request/grant plus returned read data.
interface glyph_fetch_sched_if;
    logic       i_req;
    logic [6:0] i_addr;
    logic       o_ack;
    logic [7:0] o_rdata;
    logic       o_rvalid;

    modport master (
        output i_req,
        output i_addr,
        input  o_ack,
        input  o_rdata,
        input  o_rvalid
    );

    modport slave (
        input  i_req,
        input  i_addr,
        output o_ack,
        output o_rdata,
        output o_rvalid
    );
endinterface

// File: rtl/glyph_fetch_sched.sv
// Glyph ROM arbiter: one display fetch per 16-clock cell at slot 12,
// host reads in all other slots, plus the glyph bit serialiser.
module glyph_fetch_sched #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [9:0]           i_hpos,
    input  logic [9:0]           i_vpos,
    input  logic                 i_visible,
    output logic                 o_rom_en,
    output logic [6:0]           o_rom_addr,
    input  logic [7:0]           i_rom_data,
    glyph_fetch_sched_if.slave   host,
    output logic                 o_pixel,
    output logic [2:0]           o_pal_idx
);

    typedef enum logic [1:0] {
        IDLE,
        DISP,
        HOST
    } state_t;

    localparam logic [5:0] CELLS = 6'(H_TOTAL / 16);
    localparam logic [9:0] VLAST = 10'(V_TOTAL - 1);

    state_t     r_state;
    logic [7:0] r_pref;
    logic [7:0] r_shift;
    logic [2:0] r_pend;
    logic [2:0] r_digit;
    logic [7:0] r_rdata;
    logic       r_rvalid;
    logic       r_pixel;
    logic [2:0] r_pal;

    logic [3:0] w_slot;
    logic       w_disp;
    logic       w_last;
    logic       w_host;
    logic [5:0] w_cell_nx;
    logic       w_hwrap;
    logic       w_vwrap;
    logic [3:0] w_digit;
    logic [2:0] w_row_inc;
    logic [2:0] w_row;
    logic [6:0] w_addr;

    assign w_slot = i_hpos[3:0];
    assign w_disp = (w_slot == 4'd12);
    assign w_last = (w_slot == 4'd15);
    assign w_host = host.i_req & ~w_disp;

    // At slot 12, hpos+4 is the start of the next cell.
    assign w_cell_nx = i_hpos[9:4] + 6'd1;
    assign w_hwrap   = (w_cell_nx == CELLS);
    assign w_vwrap   = (i_vpos == VLAST);
    assign w_digit   = w_hwrap ? 4'd0 : w_cell_nx[3:0];
    assign w_row_inc = i_vpos[0] ? i_vpos[3:1] + 3'd1 : i_vpos[3:1];

    always_comb begin
        w_row = i_vpos[3:1];
        if (w_hwrap) begin
            w_row = w_vwrap ? 3'd0 : w_row_inc;
        end
    end

    always_comb begin
        w_addr = 7'd0;
        unique case (1'b1)
            w_disp: w_addr = {w_digit, w_row};
            w_host: w_addr = host.i_addr;
            default: w_addr = 7'd0;
        endcase
    end

    assign o_rom_en   = i_rst_n & (w_disp | w_host);
    assign o_rom_addr = i_rst_n ? w_addr : 7'd0;
    assign host.o_ack = i_rst_n & w_host;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_pref   <= 8'd0;
            r_shift  <= 8'd0;
            r_pend   <= 3'd0;
            r_digit  <= 3'd0;
            r_rdata  <= 8'd0;
            r_rvalid <= 1'b0;
            r_pixel  <= 1'b0;
            r_pal    <= 3'd0;
        end else begin
            r_rvalid <= 1'b0;
            unique case (r_state)
                DISP: r_pref <= i_rom_data;
                HOST: begin
                    r_rdata  <= i_rom_data;
                    r_rvalid <= 1'b1;
                end
                default: ;
            endcase

            unique case (1'b1)
                w_disp: begin
                    r_state <= DISP;
                    r_pend  <= w_digit[2:0];
                end
                w_host: r_state <= HOST;
                default: r_state <= IDLE;
            endcase

            // Odd clocks advance the glyph; slot 15 reloads the next cell.
            if (w_last) begin
                r_shift <= r_pref;
                r_digit <= r_pend;
            end else if (i_hpos[0]) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end

            r_pixel <= i_visible & r_shift[7];
            r_pal   <= r_digit;
        end
    end

    assign host.o_rdata  = r_rdata;
    assign host.o_rvalid = r_rvalid;
    assign o_pixel       = r_pixel;
    assign o_pal_idx     = r_pal;

endmodule

// File: tb/tb_glyph_fetch_sched.sv
// Bench for glyph_fetch_sched: ROM model, beam driver and
// a cell-level reference for fetch addresses, host reads and pixels.
module tb_glyph_fetch_sched;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [9:0] i_hpos;
    logic [9:0] i_vpos;
    logic       i_visible;
    logic       o_rom_en;
    logic [6:0] o_rom_addr;
    logic [7:0] i_rom_data;
    logic       o_pixel;
    logic [2:0] o_pal_idx;

    glyph_fetch_sched_if hif();

    glyph_fetch_sched #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_hpos     (i_hpos),
        .i_vpos     (i_vpos),
        .i_visible  (i_visible),
        .o_rom_en   (o_rom_en),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (i_rom_data),
        .host       (hif),
        .o_pixel    (o_pixel),
        .o_pal_idx  (o_pal_idx)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] rom [128];
    logic [7:0] rom_q = 8'd0;

    always @(posedge i_clk) begin
        if (o_rom_en) rom_q <= rom[o_rom_addr];
    end
    assign i_rom_data = rom_q;

    int errors = 0;
    int checks = 0;
    int h;
    int v;
    int warm;

    logic       prev_ack = 1'b0;
    logic [6:0] prev_addr = 7'd0;
    logic [7:0] exp_rdata = 8'd0;
    logic       exp_rvalid;

    function automatic logic [6:0] disp_addr(int hh, int vv);
        int nh;
        int nv;
        nh = hh + 4;
        nv = vv;
        if (nh >= H_TOTAL) begin
            nh = nh - H_TOTAL;
            nv = (vv + 1) % V_TOTAL;
        end
        return 7'(((nh / 16) % 16) * 8 + (nv / 2) % 8);
    endfunction

    function automatic logic exp_pix(int hh, int vv, logic vis);
        logic [7:0] g;
        g = rom[7'(((hh / 16) % 16) * 8 + (vv / 2) % 8)];
        return vis & g[3'(7 - (hh % 16) / 2)];
    endfunction

    function automatic logic [2:0] exp_pal(int hh);
        return 3'((hh / 16) % 8);
    endfunction

    function automatic logic slot12(int hh);
        return (hh % 16) == 12;
    endfunction

    task automatic set_in();
        i_hpos = 10'(h);
        i_vpos = 10'(v);
    endtask

    task automatic set_beam(int nh, int nv);
        h = nh;
        v = nv;
        warm = 0;
    endtask

    task automatic next_beam();
        h++;
        if (h == H_TOTAL) begin
            h = 0;
            v = (v + 1) % V_TOTAL;
        end
    endtask

    task automatic adv();
        @(negedge i_clk);
        warm++;
    endtask

    task automatic model_pre();
        exp_rvalid = prev_ack;
        if (prev_ack) exp_rdata = rom[prev_addr];
    endtask

    task automatic model_post();
        prev_ack  = hif.i_req && !slot12(h);
        prev_addr = hif.i_addr;
    endtask

    task automatic test_reset();
        set_beam(12'h0F0, 2);
        i_visible = 1'b1;
        hif.i_req = 1'b0;
        hif.i_addr = 7'd0;
        for (int i = 0; i < 3; i++) begin
            set_in();
            adv();
            next_beam();
        end
        checks++;
        if ({o_rom_en, o_rom_addr, hif.o_ack, hif.o_rvalid, hif.o_rdata,
             o_pixel, o_pal_idx} !== 22'd0) begin
            errors++;
            $display("FAIL reset_hold outputs not zero en=%b addr=%h ack=%b pix=%b",
                     o_rom_en, o_rom_addr, hif.o_ack, o_pixel);
        end
        i_rst_n = 1'b1;
        while (h != 12'h106) begin
            set_in();
            hif.i_req = (h == 12'h105);
            hif.i_addr = 7'h55;
            adv();
            if (h == 12'h105) begin
                checks++;
                if ({hif.o_ack, o_rom_addr} !== {1'b1, 7'h55}) begin
                    errors++;
                    $display("FAIL reset_preack got ack=%b addr=%h exp ack=1 addr=55",
                             hif.o_ack, o_rom_addr);
                end
            end
            if (h != 12'h105) next_beam();
            else break;
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_rom_en, o_rom_addr, hif.o_ack, hif.o_rvalid, hif.o_rdata,
             o_pixel, o_pal_idx} !== 22'd0) begin
            errors++;
            $display("FAIL reset_async outputs not zero en=%b addr=%h ack=%b pix=%b pal=%0d",
                     o_rom_en, o_rom_addr, hif.o_ack, o_pixel, o_pal_idx);
        end
        hif.i_req = 1'b0;
        prev_ack = 1'b0;
        exp_rdata = 8'd0;
        next_beam();
        for (int i = 0; i < 2; i++) begin
            set_in();
            adv();
            next_beam();
        end
        i_rst_n = 1'b1;
        while (h != 12'h120) begin
            set_in();
            adv();
            checks++;
            if ({o_rom_en, hif.o_rvalid} !== {slot12(h), 1'b0}) begin
                errors++;
                $display("FAIL reset_after h=%0h got en=%b rvalid=%b exp en=%b rvalid=0",
                         h, o_rom_en, hif.o_rvalid, slot12(h));
            end
            if (slot12(h)) begin
                checks++;
                if (o_rom_addr !== disp_addr(h, v)) begin
                    errors++;
                    $display("FAIL reset_fetch_addr got=%h exp=%h", o_rom_addr, disp_addr(h, v));
                end
            end
            checks++;
            if (h < 12'h110) begin
                if (o_pixel !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_clean_pix h=%0h got=%b exp=0", h, o_pixel);
                end
            end else if ({o_pixel, o_pal_idx} !== {exp_pix(h, v, 1'b1), exp_pal(h)}) begin
                errors++;
                $display("FAIL reset_first_cell h=%0h got pix=%b pal=%0d exp pix=%b pal=%0d",
                         h, o_pixel, o_pal_idx, exp_pix(h, v, 1'b1), exp_pal(h));
            end
            next_beam();
        end
    endtask

    task automatic test_glyph();
        logic [15:0] pat;
        pat = 16'b1100110000110011;
        rom[7'h13] = 8'hA5;
        set_beam(12'h010, 6);
        i_visible = 1'b1;
        while (h != 12'h030) begin
            set_in();
            adv();
            if (h == 12'h01C) begin
                checks++;
                if ({o_rom_en, o_rom_addr} !== {1'b1, 7'h13}) begin
                    errors++;
                    $display("FAIL glyph_fetch got en=%b addr=%h exp en=1 addr=13",
                             o_rom_en, o_rom_addr);
                end
            end
            if (h >= 12'h020) begin
                checks++;
                if ({o_pixel, o_pal_idx} !== {pat[15 - (h - 12'h020)], 3'd2}) begin
                    errors++;
                    $display("FAIL glyph_pix h=%0h got pix=%b pal=%0d exp pix=%b pal=2",
                             h, o_pixel, o_pal_idx, pat[15 - (h - 12'h020)]);
                end
            end
            next_beam();
        end
    endtask

    task automatic test_wrap();
        int starts [2];
        logic [6:0] wexp [2];
        starts[0] = 9;
        starts[1] = 524;
        wexp[0] = 7'h05;
        wexp[1] = 7'h00;
        for (int k = 0; k < 2; k++) begin
            set_beam(780, starts[k]);
            i_visible = 1'b1;
            while (!(h == 16 && v != starts[k])) begin
                set_in();
                adv();
                if (h == 796) begin
                    checks++;
                    if ({o_rom_en, o_rom_addr} !== {1'b1, wexp[k]}) begin
                        errors++;
                        $display("FAIL wrap_addr v=%0d got en=%b addr=%h exp en=1 addr=%h",
                                 v, o_rom_en, o_rom_addr, wexp[k]);
                    end
                end
                if (h < 16) begin
                    checks++;
                    if (o_pixel !== exp_pix(h, v, 1'b1)) begin
                        errors++;
                        $display("FAIL wrap_pix v=%0d h=%0d got=%b exp=%b",
                                 v, h, o_pixel, exp_pix(h, v, 1'b1));
                    end
                end
                next_beam();
            end
        end
    endtask

    task automatic test_host_slot12();
        set_beam(12'h04A, 33);
        i_visible = 1'b1;
        hif.i_req = 1'b0;
        while (h != 12'h052) begin
            set_in();
            if (h == 12'h04C) begin
                hif.i_req = 1'b1;
                hif.i_addr = 7'h2A;
            end
            adv();
            model_pre();
            if (h == 12'h04C) begin
                checks++;
                if ({hif.o_ack, o_rom_en, o_rom_addr} !== {1'b0, 1'b1, disp_addr(h, v)}) begin
                    errors++;
                    $display("FAIL host_slot12 got ack=%b en=%b addr=%h exp ack=0 en=1 addr=%h",
                             hif.o_ack, o_rom_en, o_rom_addr, disp_addr(h, v));
                end
            end
            if (h == 12'h04D) begin
                checks++;
                if ({hif.o_ack, o_rom_en, o_rom_addr} !== {1'b1, 1'b1, 7'h2A}) begin
                    errors++;
                    $display("FAIL host_slot13 got ack=%b en=%b addr=%h exp ack=1 en=1 addr=2a",
                             hif.o_ack, o_rom_en, o_rom_addr);
                end
            end
            checks++;
            if ({hif.o_rvalid, hif.o_rdata} !== {exp_rvalid, exp_rdata}) begin
                errors++;
                $display("FAIL host_rvalid h=%0h got v=%b d=%h exp v=%b d=%h",
                         h, hif.o_rvalid, hif.o_rdata, exp_rvalid, exp_rdata);
            end
            model_post();
            if (hif.o_ack) hif.i_req = 1'b0;
            next_beam();
        end
    endtask

    task automatic test_req_held();
        int acks;
        acks = 0;
        set_beam(12'h200, 100);
        i_visible = 1'b1;
        hif.i_req = 1'b1;
        hif.i_addr = 7'($urandom);
        for (int i = 0; i < 34; i++) begin
            set_in();
            if (i >= 32) hif.i_req = 1'b0;
            adv();
            model_pre();
            if (hif.o_ack) acks++;
            checks++;
            if ({o_rom_en, hif.o_ack} !== {hif.i_req, hif.i_req && !slot12(h)}) begin
                errors++;
                $display("FAIL held_grant h=%0h got en=%b ack=%b exp en=%b ack=%b",
                         h, o_rom_en, hif.o_ack, hif.i_req, hif.i_req && !slot12(h));
            end
            if (hif.i_req) begin
                checks++;
                if (o_rom_addr !== (slot12(h) ? disp_addr(h, v) : hif.i_addr)) begin
                    errors++;
                    $display("FAIL held_addr h=%0h got=%h", h, o_rom_addr);
                end
            end
            checks++;
            if ({hif.o_rvalid, hif.o_rdata} !== {exp_rvalid, exp_rdata}) begin
                errors++;
                $display("FAIL held_rdata h=%0h got v=%b d=%h exp v=%b d=%h",
                         h, hif.o_rvalid, hif.o_rdata, exp_rvalid, exp_rdata);
            end
            model_post();
            if (prev_ack) hif.i_addr = 7'($urandom);
            next_beam();
        end
        checks++;
        if (acks != 30) begin
            errors++;
            $display("FAIL held_ack_count got=%0d exp=30", acks);
        end
    endtask

    task automatic test_blank();
        for (int d = 0; d < 16; d++) rom[7'(d * 8 + 1)] = 8'hFF;
        set_beam(12'h300, 50);
        hif.i_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            set_in();
            i_visible = (i >= 48);
            adv();
            checks++;
            if ({o_rom_en, o_pixel} !== {slot12(h), (i >= 48) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL blank h=%0h got en=%b pix=%b exp en=%b pix=%b",
                         h, o_rom_en, o_pixel, slot12(h), i >= 48);
            end
            next_beam();
        end
    endtask

    task automatic test_random();
        logic exp_en;
        logic exp_ack;
        logic [6:0] exp_addr;
        for (int r = 0; r < 4; r++) begin
            set_beam($urandom_range(0, H_TOTAL - 1), $urandom_range(0, V_TOTAL - 1));
            for (int i = 0; i < 500; i++) begin
                set_in();
                i_visible = ($urandom_range(0, 3) != 0);
                adv();
                model_pre();
                exp_ack  = hif.i_req && !slot12(h);
                exp_en   = slot12(h) || hif.i_req;
                exp_addr = slot12(h) ? disp_addr(h, v) : (hif.i_req ? hif.i_addr : 7'd0);
                checks++;
                if ({o_rom_en, o_rom_addr, hif.o_ack} !== {exp_en, exp_addr, exp_ack}) begin
                    errors++;
                    $display("FAIL rand_bus h=%0d v=%0d got en=%b addr=%h ack=%b exp en=%b addr=%h ack=%b",
                             h, v, o_rom_en, o_rom_addr, hif.o_ack, exp_en, exp_addr, exp_ack);
                end
                checks++;
                if ({hif.o_rvalid, hif.o_rdata} !== {exp_rvalid, exp_rdata}) begin
                    errors++;
                    $display("FAIL rand_rdata h=%0d got v=%b d=%h exp v=%b d=%h",
                             h, hif.o_rvalid, hif.o_rdata, exp_rvalid, exp_rdata);
                end
                if (warm >= 32) begin
                    checks++;
                    if ({o_pixel, o_pal_idx} !== {exp_pix(h, v, i_visible), exp_pal(h)}) begin
                        errors++;
                        $display("FAIL rand_pix h=%0d v=%0d got pix=%b pal=%0d exp pix=%b pal=%0d",
                                 h, v, o_pixel, o_pal_idx, exp_pix(h, v, i_visible), exp_pal(h));
                    end
                end
                model_post();
                if (hif.i_req) begin
                    if (prev_ack) begin
                        if ($urandom_range(0, 1) != 0) hif.i_addr = 7'($urandom);
                        else hif.i_req = 1'b0;
                    end else if ($urandom_range(0, 7) == 0) begin
                        hif.i_req = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    hif.i_req = 1'b1;
                    hif.i_addr = 7'($urandom);
                end
                next_beam();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
        test_reset();
        test_glyph();
        test_wrap();
        test_host_slot12();
        test_req_held();
        test_blank();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
